myproject_mac_pipe: RTL

- Parametrised, pipelined multiply-accumulate unit for HLS4ML dense/conv layers. Successor to the fixed-width combinational signed×unsigned multiplier.
- Multiplies a signed operand by a signed or unsigned operand over a frame of samples delimited by `in_last`.
- Accumulates the frame, then rounds, shifts and saturates to the layer's output width.
- Valid/ready on both sides; sits between the weight/activation streamer and the activation block.

---
 rtl/myproject_mac_pkg.sv | 45 ++++
 rtl/myproject_mac_mul_pipe.sv | 63 ++++++
 rtl/myproject_mac_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/myproject_mac_pkg.sv
// Shared helpers for the MAC pipeline: product width, output rounding/saturation
// and the term-counter saturation value.
package myproject_mac_pkg;

  // Internal width for the rounding step; sums up to 62 bits round without overflow.
  localparam int RSS_W = 64;

  typedef struct packed {
    logic [RSS_W-1:0] data;
    logic             sat;
  } rss_t;

  function automatic int p_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic logic [31:0] cnt_sat_max(input int len_w);
    return (32'd1 << len_w) - 32'd1;
  endfunction

  // Round half up, arithmetic shift right, then clamp to an out_w-bit signed range.
  function automatic rss_t round_shift_sat(input logic signed [RSS_W-1:0] sum,
                                           input int shift, input int out_w);
    rss_t                    res;
    logic signed [RSS_W-1:0] r;
    logic signed [RSS_W-1:0] max_v;
    logic signed [RSS_W-1:0] min_v;
    res = '0;
    r   = sum;
    if (shift > 0) r = (sum + (64'sd1 <<< (shift - 1))) >>> shift;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (r > max_v) begin
      res.data = max_v;
      res.sat  = 1'b1;
    end else if (r < min_v) begin
      res.data = min_v;
      res.sat  = 1'b1;
    end else begin
      res.data = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/myproject_mac_mul_pipe.sv
// Signed x signed/unsigned multiplier with STAGES clock-enabled output registers
// carrying valid/last alongside the product.
module myproject_mac_mul_pipe
  import myproject_mac_pkg::*;
#(
  parameter int A_W      = 16,
  parameter int B_W      = 11,
  parameter int B_SIGNED = 0,
  parameter int STAGES   = 2,
  parameter int P_W      = p_width(A_W, B_W)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic signed [A_W-1:0] a_i,
  input  logic        [B_W-1:0] b_i,
  output logic signed [P_W-1:0] p_o,
  output logic                  valid_o,
  output logic                  last_o
);

  logic signed [B_W:0]   b_ext;
  logic signed [P_W-1:0] a_x;
  logic signed [P_W-1:0] b_x;
  logic signed [P_W-1:0] prod;

  logic signed [P_W-1:0] p_q [STAGES];
  logic [STAGES-1:0]     v_q;
  logic [STAGES-1:0]     l_q;

  // One extra bit on b makes the unsigned case a plain signed multiply.
  assign b_ext = (B_SIGNED != 0) ? $signed({b_i[B_W-1], b_i}) : $signed({1'b0, b_i});
  assign a_x   = P_W'(a_i);
  assign b_x   = P_W'(b_ext);
  assign prod  = a_x * b_x;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= '0;
    end else if (en_i) begin
      v_q[0] <= valid_i;
      for (int i = 1; i < STAGES; i++) v_q[i] <= v_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      p_q[0] <= prod;
      l_q[0] <= last_i;
      for (int i = 1; i < STAGES; i++) begin
        p_q[i] <= p_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign p_o     = p_q[STAGES-1];
  assign valid_o = v_q[STAGES-1];
  assign last_o  = l_q[STAGES-1];

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined frame MAC: multiply, accumulate until in_last, round/shift/saturate.
// Handshake: a beat moves when valid && ready; out_* hold while out_valid && !out_ready.
module myproject_mac_pipe
  import myproject_mac_pkg::*;
#(
  parameter int A_W        = 16,
  parameter int B_W        = 11,
  parameter int B_SIGNED   = 0,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 10,
  parameter int MUL_STAGES = 2,
  parameter int LEN_W      = 8
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   in_a,
  input  logic        [B_W-1:0]   in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic        [LEN_W-1:0] out_cnt
);

  localparam int               P_W     = p_width(A_W, B_W);
  localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(cnt_sat_max(LEN_W));
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  logic                    en;
  logic                    accept;
  logic signed [P_W-1:0]   mul_p;
  logic                    mul_v;
  logic                    mul_l;

  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [LEN_W-1:0] cnt_q, cnt_d;
  logic                    start_q;
  rss_t                    rss;

  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic        [LEN_W-1:0] out_cnt_q;

  // The whole datapath freezes only while a result is waiting on downstream.
  assign en       = !(out_valid_q && !out_ready);
  assign in_ready = en && !ap_rst;
  assign accept   = in_valid && in_ready;

  myproject_mac_mul_pipe #(
    .A_W     (A_W),
    .B_W     (B_W),
    .B_SIGNED(B_SIGNED),
    .STAGES  (MUL_STAGES),
    .P_W     (P_W)
  ) u_mul (
    .clk_i  (ap_clk),
    .rst_i  (ap_rst),
    .en_i   (en),
    .valid_i(accept),
    .last_i (in_last),
    .a_i    (in_a),
    .b_i    (in_b),
    .p_o    (mul_p),
    .valid_o(mul_v),
    .last_o (mul_l)
  );

  always_comb begin
    p_ext = ACC_W'(mul_p);
    acc_d = start_q ? p_ext : acc_q + p_ext;
    cnt_d = cnt_q;
    if (start_q)               cnt_d = CNT_ONE;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    rss        = round_shift_sat(RSS_W'(acc_d), SHIFT, OUT_W);
    out_data_d = OUT_W'(rss.data);
    out_sat_d  = rss.sat;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else if (en) begin
      if (mul_v) begin
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        start_q <= mul_l;
      end
      // en implies the held result (if any) is being consumed this cycle.
      if (mul_v && mul_l) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_sat_q   <= out_sat_d;
        out_cnt_q   <= cnt_d;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_cnt   = out_cnt_q;

endmodule
